pipeline_hazard_unit: RTL and testbench

Parametrised hazard and forwarding controller for the pipelined CPU. It keeps an internal shadow pipeline of pending register writes, one record per stage after ID. From that pipeline it generates per-operand forwarding selects, load-use stalls, memory-wait freezes and gated branch redirects. It sits beside the ID-stage decoder and replaces ad-hoc EX/MEM compare logic with a depth-configurable scoreboard.

---
 rtl/pipeline_hazard_unit.sv | 127 ++++++++++++
 tb/tb_pipeline_hazard_unit.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_unit.sv
// pipeline_hazard_unit: shadow pipeline of pending register writes driving
// operand forwarding selects, load-use stalls, memory-wait freezes and
// gated branch redirects.
// Optional feature: define HAZARD_PERF_EN to add 32-bit stall/freeze/flush
// event counters as extra output ports.
module pipeline_hazard_unit #(
  parameter int AW         = 5,
  parameter int STAGES     = 3,
  parameter int LOAD_READY = 1,
  parameter int SEL_W      = $clog2(STAGES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [AW-1:0]    id_rs,
  input  logic [AW-1:0]    id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_wr_en,
  input  logic [AW-1:0]    id_wr_addr,
  input  logic             id_is_load,
  input  logic             id_branch_taken,
  input  logic             mem_ready,
  output logic [SEL_W-1:0] fwd_rs_sel,
  output logic [SEL_W-1:0] fwd_rt_sel,
  output logic             fwd_rs_load,
  output logic             fwd_rt_load,
  output logic             stall,
  output logic             freeze,
  output logic             branch_ok,
  output logic             flush_if
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]      perf_stall_cnt,
  output logic [31:0]      perf_freeze_cnt,
  output logic [31:0]      perf_flush_cnt
`endif
);

  // Record k describes the instruction currently in post-ID stage k (0 = EX).
  logic [STAGES-1:0] rec_v;
  logic [AW-1:0]     rec_addr [STAGES];
  logic [STAGES-1:0] rec_load;

  logic [SEL_W-1:0] rs_sel, rt_sel;
  logic             rs_ld, rt_ld;
  logic             rs_haz, rt_haz;
  logic             rs_active, rt_active;
  logic             stall_int, freeze_int;

  assign rs_active = id_valid && id_uses_rs && (id_rs != '0);
  assign rt_active = id_valid && id_uses_rt && (id_rt != '0);

  // Youngest-match search: scan oldest to youngest so the lowest k wins.
  always_comb begin
    rs_sel = '0;
    rs_ld  = 1'b0;
    rs_haz = 1'b0;
    rt_sel = '0;
    rt_ld  = 1'b0;
    rt_haz = 1'b0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      if (rs_active && rec_v[k] && (rec_addr[k] == id_rs)) begin
        rs_sel = SEL_W'(k + 1);
        rs_ld  = rec_load[k];
        rs_haz = rec_load[k] && (k < LOAD_READY);
      end
      if (rt_active && rec_v[k] && (rec_addr[k] == id_rt)) begin
        rt_sel = SEL_W'(k + 1);
        rt_ld  = rec_load[k];
        rt_haz = rec_load[k] && (k < LOAD_READY);
      end
    end
  end

  // Every output is held low while reset is asserted.
  assign stall_int   = !rst && (rs_haz || rt_haz);
  assign freeze_int  = !rst && !mem_ready;
  assign stall       = stall_int;
  assign freeze      = freeze_int;
  assign branch_ok   = !rst && id_branch_taken && !stall_int && !freeze_int;
  assign flush_if    = branch_ok;
  assign fwd_rs_sel  = rst ? '0 : rs_sel;
  assign fwd_rt_sel  = rst ? '0 : rt_sel;
  assign fwd_rs_load = !rst && rs_ld;
  assign fwd_rt_load = !rst && rt_ld;

  // Advance the shadow pipeline on unfrozen edges; a stall injects a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rec_v    <= '0;
      rec_load <= '0;
      for (int k = 0; k < STAGES; k++) rec_addr[k] <= '0;
    end else if (!freeze_int) begin
      for (int k = STAGES - 1; k >= 1; k--) begin
        rec_v[k]    <= rec_v[k-1];
        rec_addr[k] <= rec_addr[k-1];
        rec_load[k] <= rec_load[k-1];
      end
      if (stall_int) begin
        rec_v[0]    <= 1'b0;
        rec_addr[0] <= '0;
        rec_load[0] <= 1'b0;
      end else begin
        rec_v[0]    <= id_valid && id_wr_en && (id_wr_addr != '0);
        rec_addr[0] <= id_wr_addr;
        rec_load[0] <= id_is_load;
      end
    end
  end

`ifdef HAZARD_PERF_EN
  // Event counters; wrap naturally at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_cnt  <= '0;
      perf_freeze_cnt <= '0;
      perf_flush_cnt  <= '0;
    end else begin
      if (stall_int && !freeze_int) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (freeze_int)               perf_freeze_cnt <= perf_freeze_cnt + 32'd1;
      if (branch_ok)                perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Directed-vector bench for pipeline_hazard_unit (default parameters).
module tb_pipeline_hazard_unit;
  localparam int AW = 5;
  localparam int SEL_W = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             id_valid, id_uses_rs, id_uses_rt, id_wr_en, id_is_load;
  logic             id_branch_taken, mem_ready;
  logic [AW-1:0]    id_rs, id_rt, id_wr_addr;
  logic [SEL_W-1:0] fwd_rs_sel, fwd_rt_sel;
  logic             fwd_rs_load, fwd_rt_load, stall, freeze, branch_ok, flush_if;
`ifdef HAZARD_PERF_EN
  logic [31:0]      perf_stall_cnt, perf_freeze_cnt, perf_flush_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;

  pipeline_hazard_unit dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_wr_en(id_wr_en), .id_wr_addr(id_wr_addr), .id_is_load(id_is_load),
    .id_branch_taken(id_branch_taken), .mem_ready(mem_ready),
    .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel),
    .fwd_rs_load(fwd_rs_load), .fwd_rt_load(fwd_rt_load),
    .stall(stall), .freeze(freeze), .branch_ok(branch_ok), .flush_if(flush_if)
`ifdef HAZARD_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_freeze_cnt(perf_freeze_cnt),
    .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // valid, rs, rt, uses_rs, uses_rt, wr_en, wr_addr, is_load, branch
  task automatic set_id(input logic v, input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                        input logic urs, input logic urt, input logic we,
                        input logic [AW-1:0] wa, input logic ld, input logic br);
    id_valid = v; id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
    id_wr_en = we; id_wr_addr = wa; id_is_load = ld; id_branch_taken = br;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    mem_ready = 1'b0;
    set_id(1, 5'd8, 5'd8, 1, 1, 1, 5'd8, 1, 1);
    // Reset forces every output low even with requests pending.
    check("rst_freeze", {31'd0, freeze}, 32'd0);
    check("rst_branch", {31'd0, branch_ok}, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    mem_ready = 1'b1;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    rst = 1'b0;
    #1;

    // ALU RAW: addi r8 then read rs=8 through each stage.
    set_id(1, 0, 0, 0, 0, 1, 5'd8, 0, 0);
    tick();
    set_id(1, 5'd8, 5'd0, 1, 0, 0, 0, 0, 0);
    check("raw_sel1", {30'd0, fwd_rs_sel}, 32'd1);
    check("raw_load", {31'd0, fwd_rs_load}, 32'd0);
    check("raw_stall", {31'd0, stall}, 32'd0);
    id_uses_rs = 1'b0; #1;
    check("raw_unused", {30'd0, fwd_rs_sel}, 32'd0);
    id_uses_rs = 1'b1; #1;
    tick();
    check("raw_sel2", {30'd0, fwd_rs_sel}, 32'd2);
    tick();
    check("raw_sel3", {30'd0, fwd_rs_sel}, 32'd3);
    tick();
    check("raw_sel0", {30'd0, fwd_rs_sel}, 32'd0);

    // Load-use: lw r9 then read rt=9 -> one stall cycle, then sel 2 (load).
    set_id(1, 0, 0, 0, 0, 1, 5'd9, 1, 0);
    tick();
    set_id(1, 5'd0, 5'd9, 0, 1, 0, 0, 0, 0);
    check("lu_stall1", {31'd0, stall}, 32'd1);
    tick();
    check("lu_stall0", {31'd0, stall}, 32'd0);
    check("lu_sel2", {30'd0, fwd_rt_sel}, 32'd2);
    check("lu_load", {31'd0, fwd_rt_load}, 32'd1);
    tick();
    check("lu_sel3", {30'd0, fwd_rt_sel}, 32'd3);

    // Branch gating: taken branch held off during a load-use stall.
    set_id(1, 0, 0, 0, 0, 1, 5'd10, 1, 0);
    tick();
    set_id(1, 5'd10, 5'd0, 1, 0, 0, 0, 0, 1);
    check("br_stall", {31'd0, stall}, 32'd1);
    check("br_ok_held", {31'd0, branch_ok}, 32'd0);
    check("br_flush_held", {31'd0, flush_if}, 32'd0);
    tick();
    check("br_ok", {31'd0, branch_ok}, 32'd1);
    check("br_flush", {31'd0, flush_if}, 32'd1);
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Youngest wins, and r0 never forwards.
    set_id(1, 0, 0, 0, 0, 1, 5'd5, 0, 0);
    tick();
    tick();
    set_id(1, 5'd5, 5'd5, 1, 1, 0, 0, 0, 0);
    check("young_rs", {30'd0, fwd_rs_sel}, 32'd1);
    check("young_rt", {30'd0, fwd_rt_sel}, 32'd1);
    set_id(1, 0, 0, 0, 0, 1, 5'd0, 0, 0);
    tick();
    set_id(1, 5'd0, 5'd0, 1, 1, 0, 0, 0, 0);
    check("r0_rs", {30'd0, fwd_rs_sel}, 32'd0);
    check("r0_rt", {30'd0, fwd_rt_sel}, 32'd0);
    check("r5_after_r0w", {29'd0, 1'b0, fwd_rs_sel == 2'd0}, 32'd1);

    // Freeze: 3 frozen edges with a load in EX, stall persists, then 1 stall cycle.
    set_id(1, 0, 0, 0, 0, 1, 5'd11, 1, 0);
    tick();
    set_id(1, 5'd11, 5'd0, 1, 0, 0, 0, 0, 0);
    mem_ready = 1'b0; #1;
    for (int i = 0; i < 3; i++) begin
      check("frz_freeze", {31'd0, freeze}, 32'd1);
      check("frz_stall", {31'd0, stall}, 32'd1);
      tick();
    end
    mem_ready = 1'b1; #1;
    check("frz_rel_freeze", {31'd0, freeze}, 32'd0);
    check("frz_rel_stall", {31'd0, stall}, 32'd1);
    tick();
    check("frz_done_stall", {31'd0, stall}, 32'd0);
    check("frz_sel2", {30'd0, fwd_rs_sel}, 32'd2);
    check("frz_load", {31'd0, fwd_rs_load}, 32'd1);
`ifdef HAZARD_PERF_EN
    // Cumulative since reset: stalls from load-use, branch and freeze tests.
    check("perf_stall", perf_stall_cnt, 32'd3);
    check("perf_freeze", perf_freeze_cnt, 32'd3);
    check("perf_flush", perf_flush_cnt, 32'd1);
`endif

    // Reset mid-run with three valid records.
    set_id(1, 0, 0, 0, 0, 1, 5'd1, 0, 0);
    tick();
    set_id(1, 0, 0, 0, 0, 1, 5'd2, 0, 0);
    tick();
    set_id(1, 0, 0, 0, 0, 1, 5'd3, 0, 0);
    tick();
    set_id(1, 5'd1, 5'd3, 1, 1, 0, 0, 0, 1);
    check("pre_rst_rs", {30'd0, fwd_rs_sel}, 32'd3);
    check("pre_rst_rt", {30'd0, fwd_rt_sel}, 32'd1);
    check("pre_rst_br", {31'd0, branch_ok}, 32'd1);
    #1;
    rst = 1'b1; #1;
    check("mid_rst_rs", {30'd0, fwd_rs_sel}, 32'd0);
    check("mid_rst_rt", {30'd0, fwd_rt_sel}, 32'd0);
    check("mid_rst_br", {31'd0, branch_ok}, 32'd0);
    check("mid_rst_flush", {31'd0, flush_if}, 32'd0);
    #1;
    rst = 1'b0;
    id_branch_taken = 1'b0; #1;
    check("post_rst_rs", {30'd0, fwd_rs_sel}, 32'd0);
    check("post_rst_rt", {30'd0, fwd_rt_sel}, 32'd0);
`ifdef HAZARD_PERF_EN
    check("post_rst_perf", perf_stall_cnt | perf_freeze_cnt | perf_flush_cnt, 32'd0);
`endif
    tick();
    check("post_rst_edge_rs", {30'd0, fwd_rs_sel}, 32'd0);
    check("post_rst_edge_stall", {31'd0, stall}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
